// File: rtl/pif_led_seq_if.sv
// Command handshake bundle for the LED sequencer: one colour/duty/hold command
// per valid/ready transfer.
interface pif_led_seq_if #(
  parameter int B      = 5,
  parameter int HOLD_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_colour;
  logic [B-1:0]      cmd_duty;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (
    output cmd_valid, cmd_colour, cmd_duty, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_colour, cmd_duty, cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/pif_led_seq.sv
// Software-driven LED sequencer: buffers colour/duty/hold commands in a FIFO and
// plays each for a number of prescaler ticks through an accumulator PWM.
module pif_led_seq #(
  parameter int B          = 5,
  parameter int TICK_LEN   = 177333,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W     = 8
) (
  input  logic                          Clk,
  input  logic                          sys_rst,
  pif_led_seq_if.slave                  cmd,
  output logic                          red,
  output logic                          green,
  output logic                          tick,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(TICK_LEN);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(TICK_LEN - 1);
  localparam logic [AW:0]   FIFO_FULL    = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  if (TICK_LEN < 2) begin : g_bad_tick_len
    $error("TICK_LEN must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic [1:0]        colour;
    logic [B-1:0]      duty;
    logic [HOLD_W-1:0] hold;
  } cmd_t;

  // Command FIFO
  cmd_t          mem_q [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // Sequencer and PWM
  logic [1:0]        state_q, state_d;
  logic [1:0]        cur_colour_q, cur_colour_d;
  logic [B-1:0]      cur_duty_q, cur_duty_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [B:0]        acc_q, acc_d;
  logic              on_q, on_d;
  logic              red_q, red_d;
  logic              green_q, green_d;
  logic              run;

  assign cmd.cmd_ready = (count_q != FIFO_FULL);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (state_q == S_LOAD);
  assign head          = mem_q[rd_ptr_q];
  assign run           = (state_q == S_RUN);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset on purpose; an entry is only read after the
  // pointers show it was written, so clearing the pointers discards the contents.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{colour: cmd.cmd_colour, duty: cmd.cmd_duty, hold: cmd.cmd_hold};
    end
  end

  always_comb begin
    tick_d  = (presc_q == '0);
    presc_d = tick_d ? PRESC_RELOAD : presc_q - 1'b1;
  end

  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cur_colour_d = cur_colour_q;
    cur_duty_d   = cur_duty_q;
    hold_cnt_d   = hold_cnt_q;
    acc_d        = acc_q;
    on_d         = on_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_colour_d = head.colour;
        cur_duty_d   = head.duty;
        hold_cnt_d   = (head.hold == '0) ? HOLD_W'(1) : head.hold;
        acc_d        = '0;
        on_d         = 1'b0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        acc_d = {1'b0, acc_q[B-1:0]} + {1'b0, cur_duty_q};
        on_d  = acc_q[B];
        if (tick_q) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
          // Chain straight into the next command so busy never drops between them.
          if (hold_cnt_q == HOLD_W'(1)) state_d = (count_q != '0) ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    red_d   = !(on_q & cur_colour_q[0] & run);
    green_d = !(on_q & cur_colour_q[1] & run);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      presc_q      <= PRESC_RELOAD;
      tick_q       <= 1'b0;
      state_q      <= S_IDLE;
      cur_colour_q <= '0;
      cur_duty_q   <= '0;
      hold_cnt_q   <= '0;
      acc_q        <= '0;
      on_q         <= 1'b0;
      red_q        <= 1'b1;
      green_q      <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      state_q      <= state_d;
      cur_colour_q <= cur_colour_d;
      cur_duty_q   <= cur_duty_d;
      hold_cnt_q   <= hold_cnt_d;
      acc_q        <= acc_d;
      on_q         <= on_d;
      red_q        <= red_d;
      green_q      <= green_d;
    end
  end

  assign red        = red_q;
  assign green      = green_q;
  assign tick       = tick_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign fifo_level = count_q;

endmodule

// File: tb/tb_pif_led_seq.sv
// Directed self-checking bench for pif_led_seq with an 8-cycle tick.
module tb_pif_led_seq;

  localparam int B          = 5;
  localparam int TICK_LEN   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int HOLD_W     = 8;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          red, green, tick, busy;
  logic [LW-1:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pif_led_seq_if #(.B(B), .HOLD_W(HOLD_W)) cmd_if ();

  pif_led_seq #(
    .B(B), .TICK_LEN(TICK_LEN), .FIFO_DEPTH(FIFO_DEPTH), .HOLD_W(HOLD_W)
  ) dut (
    .Clk(clk), .sys_rst(sys_rst), .cmd(cmd_if),
    .red(red), .green(green), .tick(tick), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: returns at the following falling edge, counting posedges since release.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [B-1:0] d,
                       input logic [HOLD_W-1:0] h);
    cmd_if.cmd_valid  = v;
    cmd_if.cmd_colour = c;
    cmd_if.cmd_duty   = d;
    cmd_if.cmd_hold   = h;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_red"},   red, 1);
    check({tag, "_green"}, green, 1);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_ready"}, cmd_if.cmd_ready, 1);
    check({tag, "_tick"},  tick, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      step();
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Posedge at which RUN (entered at posedge r) consumes its first tick.
  function automatic int first_tick_edge(input int r);
    return TICK_LEN * ((r + TICK_LEN - 1) / TICK_LEN) + 1;
  endfunction

  initial begin
    int n_acc, r, e, ra, ea, rb, eb, lows, lr, lg, accepted, first_acc, rise, nb, nl;
    logic red_exp;

    drive(0, 2'd0, '0, '0);
    #1 sys_rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    cyc = 0;

    // Prescaler: first pulse TICK_LEN cycles after release, then periodic.
    for (int k = 1; k <= 2 * TICK_LEN; k++) begin
      step();
      check("tick_phase", tick, (k % TICK_LEN) == 0);
    end

    // Single command: red at duty 16 toggles, green stays off, 2 ticks long.
    drive(1, 2'd1, 5'd16, 8'd2);
    step();
    n_acc = cyc;
    drive(0, 2'd0, '0, '0);
    check("single_level_acc", fifo_level, 1);
    check("single_busy_acc", busy, 0);
    r = n_acc + 2;
    e = first_tick_edge(r) + TICK_LEN;
    while (cyc < e + 2) begin
      step();
      red_exp = !((cyc - r) >= 4 && ((cyc - r) % 2) == 0 && cyc <= e);
      check("single_red", red, red_exp);
      check("single_green", green, 1);
      check("single_busy", busy, cyc < e);
      check("single_level", fifo_level, (cyc <= n_acc + 1) ? 1 : 0);
    end

    // Duty 0 on both colours never lights.
    drive(1, 2'd3, 5'd0, 8'd8);
    step();
    drive(0, 2'd0, '0, '0);
    repeat (2) step();
    lows = 0;
    repeat (64) begin
      step();
      if (!red)   lows++;
      if (!green) lows++;
    end
    check("duty0_lows", lows, 0);
    wait_idle("duty0_idle");

    // Duty 31: 31 low cycles in a 32-cycle RUN window on each colour.
    drive(1, 2'd3, 5'd31, 8'd8);
    step();
    drive(0, 2'd0, '0, '0);
    repeat (2) step();
    lr = 0;
    lg = 0;
    for (int j = 1; j <= 35; j++) begin
      step();
      if (j >= 4) begin
        if (!red)   lr++;
        if (!green) lg++;
      end
    end
    check("duty31_red_lows", lr, 31);
    check("duty31_green_lows", lg, 31);
    wait_idle("duty31_idle");

    // Back-pressure: six hold=255 commands offered, five fit.
    drive(1, 2'd1, 5'd16, 8'd255);
    accepted  = 0;
    first_acc = -1;
    for (int i = 0; i < 10; i++) begin
      if (cmd_if.cmd_ready && accepted < 6) begin
        accepted++;
        if (first_acc < 0) first_acc = cyc + 1;
      end
      step();
    end
    check("bp_accepted", accepted, 5);
    check("bp_level_full", fifo_level, 4);
    check("bp_ready_low", cmd_if.cmd_ready, 0);
    r    = first_acc + 2;
    rise = first_tick_edge(r) + TICK_LEN * 254 + 1;
    while (!cmd_if.cmd_ready && cyc < rise + 20) step();
    check("bp_ready_rise_cyc", cyc, rise);
    check("bp_ready_high", cmd_if.cmd_ready, 1);
    check("bp_level_after_pop", fifo_level, 3);
    step();
    drive(0, 2'd0, '0, '0);
    check("bp_level_refill", fifo_level, 4);
    check("bp_ready_relow", cmd_if.cmd_ready, 0);
    check("bp_busy", busy, 1);

    // Asynchronous reset mid-stream; pushes during reset are ignored.
    #2 sys_rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    drive(1, 2'd3, 5'd31, 8'd5);
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    drive(0, 2'd0, '0, '0);
    cyc = 0;
    for (int k = 1; k <= TICK_LEN; k++) begin
      step();
      check("rst_mid_tick_phase", tick, k == TICK_LEN);
    end
    check("rst_mid_level_after", fifo_level, 0);
    check("rst_mid_busy_after", busy, 0);

    // Chaining: hold=0 lasts one tick, hold=3 lasts three, busy never drops.
    drive(1, 2'd2, 5'd10, 8'd0);
    step();
    n_acc = cyc;
    drive(1, 2'd1, 5'd20, 8'd3);
    step();
    drive(0, 2'd0, '0, '0);
    check("chain_level2", fifo_level, 2);
    check("chain_busy_load", busy, 1);
    ra = n_acc + 2;
    ea = first_tick_edge(ra);
    rb = ea + 1;
    eb = first_tick_edge(rb) + 2 * TICK_LEN;
    while (cyc < eb + 1) begin
      step();
      check("chain_busy", busy, cyc < eb);
      check("chain_level", fifo_level, (cyc <= ea) ? 1 : 0);
    end

    // Reset during RUN with three commands queued.
    drive(1, 2'd3, 5'd31, 8'd255);
    repeat (4) step();
    drive(0, 2'd0, '0, '0);
    check("rst_run_level3", fifo_level, 3);
    check("rst_run_busy", busy, 1);
    repeat (12) step();
    check("rst_run_pre_red", red, 0);
    check("rst_run_pre_green", green, 0);
    #2 sys_rst = 1'b1;
    #1 check_reset_outputs("rst_run");
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    cyc = 0;
    nb = 0;
    nl = 0;
    repeat (40) begin
      step();
      if (busy) nb++;
      if (!red || !green) nl++;
    end
    check("rst_run_busy_cycles", nb, 0);
    check("rst_run_led_cycles", nl, 0);
    check("rst_run_level_after", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
